msx_mouse_reader: RTL

- Host-side reader for the MSX joystick-port mouse protocol.
- Drives the port strobe (STR) and times four nibble reads per frame.
- Assembles signed X/Y deltas and button state, presenting them to the system with a valid pulse.
- Sits between a physical/virtual MSX joystick port and any consumer needing pointer data, e.g. the OSD or a PS/2 mouse bridge.

---
 rtl/msx_mouse_reader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/msx_mouse_reader.sv
// Host-side MSX joystick-port mouse reader: strobes the port, reads four nibbles per frame,
// and presents signed X/Y deltas and buttons. Define MSX_MOUSE_ACCUM_EN for saturating accumulators.
module msx_mouse_reader #(
  parameter int DELAY  = 1000,
  parameter int PERIOD = 400000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       enable,
`ifdef MSX_MOUSE_ACCUM_EN
  input  logic       acc_clr,
`endif
  input  logic [5:0] joy_in,
  output logic       stra,
  output logic [7:0] dx,
  output logic [7:0] dy,
  output logic [1:0] btn,
  output logic       valid,
  output logic       present,
  output logic       busy
);

  localparam int PER_W = $clog2(PERIOD + 1);
  localparam int DLY_W = $clog2(DELAY + 1);

  typedef enum logic [2:0] {IDLE, TOGGLE, WAIT, SAMPLE, DONE} state_t;

  state_t            state, state_nxt;
  logic [5:0]        joy_p0, joy_p1;
  logic [PER_W-1:0]  per_cnt;
  logic [DLY_W-1:0]  dly_cnt;
  logic [1:0]        idx;
  logic [3:0][3:0]   slot;
  logic              per_done, dly_done, all_f;
  logic signed [7:0] x_raw, y_raw, dx_new;

  function automatic logic signed [7:0] neg_wrap(input logic signed [7:0] v);
    return 8'sd0 - v;
  endfunction

`ifdef MSX_MOUSE_ACCUM_EN
  function automatic logic signed [7:0] sat_add(input logic signed [7:0] a,
                                                input logic signed [7:0] b);
    logic signed [8:0] s;
    s = {a[7], a} + {b[7], b};
    if (s > 9'sd127)
      return 8'sd127;
    else if (s < -9'sd128)
      return -8'sd128;
    return s[7:0];
  endfunction
`endif

  assign per_done = (per_cnt == PER_W'(PERIOD - 1));
  assign dly_done = (dly_cnt == DLY_W'(DELAY - 1));
  assign x_raw    = {slot[0], slot[1]};
  assign y_raw    = {slot[2], slot[3]};
  assign dx_new   = neg_wrap(x_raw);
  // An all-ones frame is what an idle joystick reads; it is not treated as a mouse
  assign all_f    = &slot;

  // Stage p0/p1: two-flop synchronizer on the raw port pins
  always_ff @(posedge clk_sys) begin
    joy_p0 <= joy_in;
    joy_p1 <= joy_p0;
  end

  always_ff @(posedge clk_sys) begin
    if (state == SAMPLE)
      slot[idx] <= joy_p1[3:0];
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (per_done && enable) state_nxt = TOGGLE;
      TOGGLE:  state_nxt = WAIT;
      WAIT:    if (dly_done) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = (idx == 2'd3) ? DONE : TOGGLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      per_cnt <= '0;
      dly_cnt <= '0;
      idx     <= '0;
      stra    <= 1'b0;
      busy    <= 1'b0;
      valid   <= 1'b0;
      present <= 1'b0;
      btn     <= '0;
      dx      <= '0;
      dy      <= '0;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!per_done)
            per_cnt <= per_cnt + 1'b1;
          else if (enable)
            per_cnt <= '0;
        end
        TOGGLE: begin
          stra    <= ~stra;
          busy    <= 1'b1;
          dly_cnt <= '0;
        end
        WAIT:   dly_cnt <= dly_cnt + 1'b1;
        SAMPLE: idx <= idx + 1'b1;
        DONE: begin
          btn     <= ~joy_p1[5:4];
          present <= ~all_f;
          valid   <= ~all_f;
          idx     <= '0;
          busy    <= 1'b0;
          per_cnt <= '0;
        end
        default: ;
      endcase
`ifdef MSX_MOUSE_ACCUM_EN
      // A clear coinciding with a new frame keeps only the new delta
      if (state == DONE && !all_f) begin
        dx <= acc_clr ? dx_new : sat_add(dx, dx_new);
        dy <= acc_clr ? y_raw  : sat_add(dy, y_raw);
      end else if (acc_clr) begin
        dx <= '0;
        dy <= '0;
      end
`else
      if (state == DONE && !all_f) begin
        dx <= dx_new;
        dy <= y_raw;
      end
`endif
    end
  end

endmodule
